// File: rtl/csi2_video_frame_gate_if.sv
// rtl/csi2_video_frame_gate_if.sv - video stream bundle (tdata/tvalid/tready/tuser/tlast)
interface csi2_video_frame_gate_if #(
  parameter int DATA_WIDTH = 16
) ();
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tuser;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

// File: rtl/csi2_video_frame_gate.sv
// rtl/csi2_video_frame_gate.sv - frame geometry gate with 2-entry registered skid output
// Optional stats counters enabled by `define CSI2_FRAME_GATE_STATS_EN.
module csi2_video_frame_gate #(
  parameter int DATA_WIDTH  = 16,
  parameter int LINE_BEATS  = 960,
  parameter int FRAME_LINES = 1080
) (
  input  logic                     px_clk_i,
  input  logic                     px_arstn_i,
  csi2_video_frame_gate_if.slave   video_in,
  csi2_video_frame_gate_if.master  video_out,
  output logic                     frame_done_o,
  output logic                     err_short_o,
  output logic                     err_long_o,
  output logic                     err_sof_o
`ifdef CSI2_FRAME_GATE_STATS_EN
  ,
  output logic [31:0]              frame_cnt_o,
  output logic [31:0]              err_cnt_o
`endif
);

  localparam int BW = $clog2(LINE_BEATS);
  localparam int LW = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;
  localparam int EW = DATA_WIDTH + 2;
  localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_BEATS - 1);
  localparam logic [LW-1:0] LAST_LINE = LW'(FRAME_LINES - 1);
  localparam logic [0:0] S_WAIT_SOF = 1'b0;
  localparam logic [0:0] S_IN_FRAME = 1'b1;

  logic [1:0]    rst_sync_q, rst_sync_d;
  logic          rst_n;
  logic [0:0]    state_q, state_d;
  logic [BW-1:0] beat_cnt_q, beat_cnt_d;
  logic [LW-1:0] line_cnt_q, line_cnt_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [EW-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
  logic          frame_done_q, frame_done_d;
  logic          err_short_q, err_short_d;
  logic          err_long_q, err_long_d;
  logic          err_sof_q, err_sof_d;
  logic          tready, accept, push, pop, fwd_last;
  logic [EW-1:0] new_ent;

  assign rst_sync_d = {rst_sync_q[0], 1'b1};
  assign rst_n      = rst_sync_q[1];

  always_ff @(posedge px_clk_i or negedge px_arstn_i) begin
    if (!px_arstn_i) rst_sync_q <= 2'b00;
    else             rst_sync_q <= rst_sync_d;
  end

  // Non-SOF beats in WAIT_SOF are always swallowed; a SOF beat must wait for skid space.
  assign tready = (cnt_q == 2'd2) ? (state_q == S_WAIT_SOF && !video_in.tuser) : 1'b1;
  assign accept = video_in.tvalid & tready;
  assign pop    = (cnt_q != 2'd0) & video_out.tready;

  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    line_cnt_d   = line_cnt_q;
    push         = 1'b0;
    fwd_last     = video_in.tlast;
    frame_done_d = 1'b0;
    err_short_d  = 1'b0;
    err_long_d   = 1'b0;
    err_sof_d    = 1'b0;
    if (accept) begin
      if (video_in.tuser) begin
        push       = 1'b1;
        err_sof_d  = (state_q == S_IN_FRAME);
        beat_cnt_d = BW'(1);
        line_cnt_d = '0;
        if (state_q == S_WAIT_SOF && video_in.tlast) begin
          err_short_d = 1'b1;
          beat_cnt_d  = '0;
        end else begin
          state_d = S_IN_FRAME;
        end
      end else if (state_q == S_IN_FRAME) begin
        push = 1'b1;
        if (video_in.tlast && beat_cnt_q == LAST_BEAT) begin
          beat_cnt_d = '0;
          if (line_cnt_q == LAST_LINE) begin
            frame_done_d = 1'b1;
            line_cnt_d   = '0;
            state_d      = S_WAIT_SOF;
          end else begin
            line_cnt_d = line_cnt_q + LW'(1);
          end
        end else if (video_in.tlast) begin
          err_short_d = 1'b1;
          state_d     = S_WAIT_SOF;
        end else if (beat_cnt_q == LAST_BEAT) begin
          fwd_last   = 1'b1;
          err_long_d = 1'b1;
          state_d    = S_WAIT_SOF;
        end else begin
          beat_cnt_d = beat_cnt_q + BW'(1);
        end
      end
    end
  end

  assign new_ent = {video_in.tuser, fwd_last, video_in.tdata};

  // Head entry always drives the output; push never meets a full, non-popping skid.
  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;
    case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) ent0_d = new_ent;
        else               ent1_d = new_ent;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        ent0_d = ent1_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          ent0_d = new_ent;
        end else begin
          ent0_d = ent1_q;
          ent1_d = new_ent;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge px_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_WAIT_SOF;
      beat_cnt_q   <= '0;
      line_cnt_q   <= '0;
      cnt_q        <= 2'd0;
      ent0_q       <= '0;
      ent1_q       <= '0;
      frame_done_q <= 1'b0;
      err_short_q  <= 1'b0;
      err_long_q   <= 1'b0;
      err_sof_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      line_cnt_q   <= line_cnt_d;
      cnt_q        <= cnt_d;
      ent0_q       <= ent0_d;
      ent1_q       <= ent1_d;
      frame_done_q <= frame_done_d;
      err_short_q  <= err_short_d;
      err_long_q   <= err_long_d;
      err_sof_q    <= err_sof_d;
    end
  end

  assign video_in.tready  = tready;
  assign video_out.tvalid = (cnt_q != 2'd0);
  assign video_out.tuser  = ent0_q[EW-1];
  assign video_out.tlast  = ent0_q[EW-2];
  assign video_out.tdata  = ent0_q[DATA_WIDTH-1:0];
  assign frame_done_o     = frame_done_q;
  assign err_short_o      = err_short_q;
  assign err_long_o       = err_long_q;
  assign err_sof_o        = err_sof_q;

`ifdef CSI2_FRAME_GATE_STATS_EN
  logic [31:0] frame_cnt_q, frame_cnt_d, err_cnt_q, err_cnt_d;
  logic        err_any;

  assign err_any     = err_short_q | err_long_q | err_sof_q;
  assign frame_cnt_d = frame_cnt_q + {31'd0, frame_done_q};
  assign err_cnt_d   = (err_any && err_cnt_q != 32'hFFFF_FFFF) ? err_cnt_q + 32'd1 : err_cnt_q;

  always_ff @(posedge px_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= 32'd0;
      err_cnt_q   <= 32'd0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign frame_cnt_o = frame_cnt_q;
  assign err_cnt_o   = err_cnt_q;
`endif

endmodule
